// File: rtl/alu_pipe.sv
// alu_pipe: elastic two-ALU pipeline computing (op1 opA op2) opB op1 with valid/ready flow control.
// Defining ALU_PIPE_FLAGS_EN adds registered zero_o/neg_o result flags.
module alu_pipe #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DWIDTH-1:0]          op1_i,
    input  logic [DWIDTH-1:0]          op2_i,
    input  logic [1:0]                 mode_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DWIDTH-1:0]          res_o,
`ifdef ALU_PIPE_FLAGS_EN
    output logic                       zero_o,
    output logic                       neg_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH:1]    valid;
    logic [DEPTH:1]    ready;
    logic              accept;
    logic              consume;
    logic [CW-1:0]     count;

    logic [DWIDTH-1:0] s1_op1;
    logic [DWIDTH-1:0] s1_op2;
    logic [1:0]        s1_mode;
    logic [DWIDTH-1:0] s2_res;
    logic [DWIDTH-1:0] s2_op1;
    logic [1:0]        s2_mode;
    logic [DWIDTH-1:0] res_q [3:DEPTH];
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;

    // ready_k = !valid_k || ready_{k+1}, unrolled as a running OR from the output end
    always_comb begin : ready_chain
        logic acc;
        acc   = out_ready_i;
        ready = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            acc              = acc || !valid[DEPTH - i];
            ready[DEPTH - i] = acc;
        end
    end

    assign in_ready_o  = rst && !flush_i && ready[1];
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = valid[DEPTH];
    assign consume     = out_valid_o && out_ready_i;
    assign res_o       = res_q[DEPTH];
    assign count_o     = count;

    // ALU A subtracts for SUB_ADD/SUB_SUB; ALU B subtracts for ADD_SUB/SUB_SUB
    assign alu_a = s1_mode[0] ? s1_op1 - s1_op2 : s1_op1 + s1_op2;
    assign alu_b = (s2_mode[1] == s2_mode[0]) ? s2_res - s2_op1 : s2_res + s2_op1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            count <= '0;
        end else if (flush_i) begin
            valid <= '0;
            count <= '0;
        end else begin
            if (ready[1]) valid[1] <= accept;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                if (ready[k]) valid[k] <= valid[k-1];
            end
            count <= count + CW'(accept) - CW'(consume);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_op1  <= '0;
            s1_op2  <= '0;
            s1_mode <= '0;
            s2_res  <= '0;
            s2_op1  <= '0;
            s2_mode <= '0;
            for (int unsigned k = 3; k <= DEPTH; k++) res_q[k] <= '0;
        end else begin
            if (accept) begin
                s1_op1  <= op1_i;
                s1_op2  <= op2_i;
                s1_mode <= mode_i;
            end
            if (ready[2] && valid[1]) begin
                s2_res  <= alu_a;
                s2_op1  <= s1_op1;
                s2_mode <= s1_mode;
            end
            if (ready[3] && valid[2]) res_q[3] <= alu_b;
            for (int unsigned k = 4; k <= DEPTH; k++) begin
                if (ready[k] && valid[k-1]) res_q[k] <= res_q[k-1];
            end
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic zero_q [3:DEPTH];
    logic neg_q  [3:DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 3; k <= DEPTH; k++) begin
                zero_q[k] <= 1'b0;
                neg_q[k]  <= 1'b0;
            end
        end else begin
            if (ready[3] && valid[2]) begin
                zero_q[3] <= (alu_b == '0);
                neg_q[3]  <= alu_b[DWIDTH-1];
            end
            for (int unsigned k = 4; k <= DEPTH; k++) begin
                if (ready[k] && valid[k-1]) begin
                    zero_q[k] <= zero_q[k-1];
                    neg_q[k]  <= neg_q[k-1];
                end
            end
        end
    end

    assign zero_o = out_valid_o && zero_q[DEPTH];
    assign neg_o  = out_valid_o && neg_q[DEPTH];
`endif

endmodule

// File: doc/alu_pipe.md
# alu_pipe

- Elastic, parametrised two-ALU datapath pipeline with valid/ready handshakes on input and output.
- Each beat carries two operands and a mode; the result is `op1 (opA) op2`, then `(that) (opB) op1`, with opA/opB ∈ {ADD, SUB} chosen by the mode.
- Register depth is configurable and bubbles collapse under backpressure.
- Sits between an operand producer and a result consumer that may stall.

## Interface
- `DWIDTH`, default 8: operand/result width in bits.
- `DEPTH`, default 3: number of register stages, minimum 3. Stages 1–3 are fixed as listed in Operation; stages 4..DEPTH are pure delay.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `in_valid_i` input, 1 bit: input beat present.
- `in_ready_o` output, 1 bit: pipeline can accept a beat this cycle.
- `op1_i` input, DWIDTH bits: operand 1.
- `op2_i` input, DWIDTH bits: operand 2.
- `mode_i` input, 2 bits: function select.
  - 0 ADD_SUB: `(op1+op2)-op1`
  - 1 SUB_ADD: `(op1-op2)+op1`
  - 2 ADD_ADD: `(op1+op2)+op1`
  - 3 SUB_SUB: `(op1-op2)-op1`
- `flush_i` input, 1 bit: drop all in-flight beats.
- `out_valid_o` output, 1 bit: result present.
- `out_ready_i` input, 1 bit: consumer accepts result.
- `res_o` output, DWIDTH bits: result.
- `count_o` output, $clog2(DEPTH+1) bits: number of valid beats in flight.

## Operation
**Stages**
- Stage 1 registers `op1`, `op2` and `mode`.
- ALU A sits between stage 1 and stage 2. It is combinational and computes `op1 ± op2` per `mode[1]`/`mode[0]` decode.
- Stage 2 registers the ALU A result, `op1` and `mode`.
- ALU B computes `resA ± op1`.
- Stage 3 registers the ALU B result. Stages 4..DEPTH shift it unchanged.
- `res_o` is the last stage's data. `out_valid_o` is the last stage's valid bit.

**Arithmetic**
- Unsigned and modulo 2^DWIDTH; carries and borrows are discarded.
- No overflow indication.

**Flow control**
- Each stage has a valid bit and loads when `ready_k = !valid_k || ready_{k+1}`.
- `ready_{DEPTH+1}` is `out_ready_i`, and `in_ready_o = ready_1`.
- A stage that is not loading holds its data and valid bit. Data in empty stages is don't-care but must not reach `res_o` while `out_valid_o` is high.
- A beat is accepted when `in_valid_i && in_ready_o`. A result is consumed when `out_valid_o && out_ready_i`.
- Bubbles collapse: a stalled output still lets upstream empty stages fill.

**Occupancy**
- `count_o` is a registered counter.
- +1 on accept, −1 on consume, unchanged when both happen in the same cycle.
- Must always equal the number of set valid bits.

**Flush**
- `flush_i` high at an edge clears every valid bit and `count_o`.
- `in_ready_o` is forced 0 while `flush_i` is high, so no beat is accepted that cycle.
- A result presented during the flush cycle that is consumed is counted as delivered.

**Reset**
- While `rst` is low: all valid bits 0, all data registers 0, `res_o` 0, `out_valid_o` 0, `count_o` 0, `in_ready_o` 0.
- `in_ready_o` returns to 1 in the first cycle after `rst` deasserts.
- Reset asserted mid-operation discards all in-flight beats immediately, without waiting for a clock edge.

## Timing
- Latency: a beat accepted at edge E with no downstream stall gives `out_valid_o` = 1 and `res_o` valid after edge E+DEPTH−1.
- Throughput: one beat per cycle when `out_ready_i` is held high.
- Output stability: while `out_valid_o && !out_ready_i`, `res_o` and `out_valid_o` must stay stable.
- Full: pipeline is full when all DEPTH valid bits are set and `out_ready_i` = 0. Then `in_ready_o` = 0 and `count_o` = DEPTH.
- Full with consumer ready: with `out_ready_i` = 1, `in_ready_o` = 1 in the same cycle (combinational ready chain). Accept and consume on the same edge leave `count_o` = DEPTH.
- `in_ready_o` depends combinationally on `out_ready_i`, `flush_i`, `rst` and the valid bits. All other outputs are registered.

## Configuration
- `ALU_PIPE_FLAGS_EN` defined: adds outputs `zero_o` and `neg_o` (1 bit each).
  - `zero_o` = (result == 0); `neg_o` = result[DWIDTH−1].
  - Both are registered in stage 3, shifted alongside the data, and qualified by `out_valid_o`.
  - Both reset to 0.
- `ALU_PIPE_FLAGS_EN` undefined: the ports do not exist and no flag logic is built. All other behaviour is identical.

## Test plan
- Reset, then with DWIDTH=8, DEPTH=3 and `out_ready_i` = 1, send `op1`=0x10, `op2`=0x05 in all four modes back-to-back → results 0x05, 0x1B, 0x25, 0xFB on four consecutive cycles starting 2 edges after the first accept.
- Wrap case: `op1`=0xF0, `op2`=0x20, ADD_ADD → `res_o` = 0x00; with `ALU_PIPE_FLAGS_EN`, `zero_o` = 1 and `neg_o` = 0. SUB_SUB with `op1`=0x01, `op2`=0x02 → 0xFE, `neg_o` = 1.
- Backpressure: hold `out_ready_i` = 0 and offer 5 beats → exactly 3 accepted, `count_o` = 3, `in_ready_o` = 0, `res_o` stable. Release → remaining beats drain in order, with no loss or duplication.
- Bubble collapse: hold `out_ready_i` = 0 with one beat at the output and stages 1–2 empty → the next two offered beats are accepted on consecutive cycles.
- Flush with `count_o` = 3 → after the edge, `count_o` = 0 and `out_valid_o` = 0. The beat offered during the flush cycle is not accepted.
- Drive `rst` low asynchronously mid-stream → outputs go to 0 immediately, before the next edge. After release, the first new beat appears with the normal latency.
